ex_div: RTL

//  Iterative radix-2 divider for DIV/DIVU in the EX stage. Drives stallreq_for_ex

---
 rtl/ex_div_pkg.sv | 16 +
 rtl/ex_div_if.sv | 27 ++
 rtl/ex_div.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared constants and types for the EX-stage iterative divider.
package ex_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic [DIV_WIDTH-1:0] quo;
    } div_result_t;

endpackage

// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface ex_div_if
    import ex_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stallreq_for_ex;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stallreq_for_ex
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stallreq_for_ex
    );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held while ready, stall request to CTRL.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic    clk,
    input  logic    resetn,
    ex_div_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         r_state,   w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [2*WIDTH-1:0] r_work,    w_work_nxt;
    logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
    logic               r_neg_quo, w_neg_quo_nxt;
    logic               r_neg_rem, w_neg_rem_nxt;
    logic [2*WIDTH-1:0] r_result,  w_result_nxt;
    logic               r_ready,   w_ready_nxt;

    // Operand magnitudes; abs(most-negative) naturally wraps to its unsigned value
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_a_neg = bus.signed_div & bus.opdata1[WIDTH-1];
    assign w_b_neg = bus.signed_div & bus.opdata2[WIDTH-1];
    assign w_abs_a = w_a_neg ? -bus.opdata1 : bus.opdata1;
    assign w_abs_b = w_b_neg ? -bus.opdata2 : bus.opdata2;

    // One shift-subtract step: r_work = {partial remainder, dividend/quotient bits}
    logic [WIDTH:0]   w_hi;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic             w_last;

    assign w_hi       = r_work[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_hi >= {1'b0, r_divisor});
    assign w_rem_step = w_ge ? WIDTH'(w_hi - {1'b0, r_divisor}) : w_hi[WIDTH-1:0];
    assign w_quo_step = {r_work[WIDTH-2:0], w_ge};
    assign w_rem_fix  = r_neg_rem ? -w_rem_step : w_rem_step;
    assign w_quo_fix  = r_neg_quo ? -w_quo_step : w_quo_step;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state and datapath update
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_neg_quo_nxt = r_neg_quo;
        w_neg_rem_nxt = r_neg_rem;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        case (r_state)
            DIV_IDLE: begin
                w_ready_nxt = 1'b0;
                if (bus.start && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        w_state_nxt = DIV_BYZERO;
                    end else begin
                        w_state_nxt   = DIV_ON;
                        w_cnt_nxt     = '0;
                        w_work_nxt    = {{WIDTH{1'b0}}, w_abs_a};
                        w_divisor_nxt = w_abs_b;
                        w_neg_quo_nxt = w_a_neg ^ w_b_neg;
                        w_neg_rem_nxt = w_a_neg;
                    end
                end
            end
            DIV_BYZERO: begin
                if (bus.annul) begin
                    w_state_nxt = DIV_IDLE;
                end else begin
                    w_state_nxt  = DIV_END;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b1;
                end
            end
            DIV_ON: begin
                if (bus.annul) begin
                    w_state_nxt = DIV_IDLE;
                end else begin
                    w_work_nxt = {w_rem_step, w_quo_step};
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state_nxt  = DIV_END;
                        w_result_nxt = {w_rem_fix, w_quo_fix};
                        w_ready_nxt  = 1'b1;
                    end
                end
            end
            DIV_END: begin
                if (bus.annul || !bus.start) begin
                    w_state_nxt = DIV_IDLE;
                    w_ready_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = DIV_IDLE;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_quo <= w_neg_quo_nxt;
            r_neg_rem <= w_neg_rem_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign bus.result          = r_result;
    assign bus.ready           = r_ready;
    assign bus.stallreq_for_ex = bus.start & ~r_ready;

endmodule
